axi_rd_arbiter: RTL
===================

AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
Parameters:
REQ-001 TIMEOUT, 1024, max idle cycles in DATA with no R handshake before abort; SHALL be >= 2.
REQ-002 CNT_W, $clog2(TIMEOUT+1), width of watchdog counter.
Ports:
REQ-003 ACLK  in  1  single clock; all state SHALL update on rising edge.
REQ-004 ARESETn  in  1  asynchronous, active-low reset.
REQ-005 m0_arvalid  in  1  master 0 read-address request.
REQ-006 m1_arvalid  in  1  master 1 read-address request.
REQ-007 s_arready  in  1  ARREADY of the slave side of the AR mux.
REQ-008 s_rvalid  in  1  RVALID returned through the R mux.
REQ-009 s_rready  in  1  RREADY of the granted master, seen through the R mux.
REQ-010 s_rlast  in  1  RLAST returned through the R mux.
REQ-011 sel  out  `AXI_POINTER_BITS  granted master, Pointer encoding SEL0/SEL1; drives the mux pointer.
REQ-012 ar_en  out  1  high when the AR channel of the granted master may pass.
REQ-013 r_en  out  1  high when the R channel of the granted master may pass.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 timeout_err  out  1  single-cycle pulse on watchdog abort.
REQ-016 beat_cnt  out  8  R beats accepted in the current burst; saturates at 255.

Function
REQ-017 FSM states: IDLE, ADDR, DATA; all outputs SHALL be registered.
REQ-018 IDLE: if either m*_arvalid=1, the next state SHALL be ADDR and sel SHALL load the winner; otherwise stay in IDLE.
REQ-019 Single request: grant that master. Both requesting: grant the master not equal to last_grant (round robin).
REQ-020 last_grant SHALL update to the winner when AR is accepted (ADDR->DATA), not when the grant is issued.
REQ-021 Latency: a request sampled in IDLE at edge N SHALL give ar_en=1 after edge N; no combinational path from m*_arvalid to any output.
REQ-022 ADDR: ar_en=1, r_en=0; on (granted m*_arvalid & s_arready) go to DATA, clear beat_cnt and the watchdog.
REQ-023 ADDR: if the granted master deasserts arvalid, SHALL stay in ADDR; the grant SHALL NOT move to the other master.
REQ-024 DATA: ar_en=0, r_en=1; each s_rvalid & s_rready SHALL increment beat_cnt (saturating) and clear the watchdog.
REQ-025 DATA: handshake with s_rlast=1 SHALL go to IDLE after that edge; sel SHALL hold its value in IDLE.
REQ-026 Watchdog: in DATA, counts cycles without a handshake; reaching TIMEOUT SHALL go to IDLE and pulse timeout_err for exactly 1 cycle.
REQ-027 Handshake and timeout in the same cycle: the handshake SHALL win, with no timeout_err.
REQ-028 Only one transaction outstanding; new requests are ignored until IDLE is re-entered, after which re-arbitration costs 1 cycle.
REQ-029 sel SHALL change only on the IDLE->ADDR transition.

Reset
REQ-030 ARESETn low, at any time including mid-burst, SHALL immediately force: state=IDLE, sel=SEL0, ar_en=0, r_en=0, busy=0, timeout_err=0, beat_cnt=0, watchdog=0, last_grant=SEL1 (master 0 wins the first tie).
REQ-031 Reset deassertion SHALL be taken synchronously to ACLK; the first arbitration happens on the first edge after release.

Verification
REQ-032 After reset, m0 and m1 request together -> sel=SEL0, ar_en=1 next cycle. Then s_arready=1 -> DATA. Then 4 beats, last with rlast -> beat_cnt=4, IDLE.
REQ-033 Both masters request continuously for 4 bursts -> grant order SEL0, SEL1, SEL0, SEL1; each burst 1 beat with a 1-cycle IDLE gap.
REQ-034 TIMEOUT=8, no s_rvalid in DATA -> timeout_err pulses once 8 cycles after entering DATA, then IDLE with busy=0.
REQ-035 Handshake on the exact TIMEOUT cycle -> no timeout_err, watchdog cleared, burst continues.
REQ-036 ARESETn asserted mid-DATA after 3 beats -> all outputs take reset values asynchronously; the next request is granted with normal latency.
REQ-037 300-beat burst -> beat_cnt saturates at 255 and the burst ends normally on rlast.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter: round-robin grant of the AR/R mux pointer, one transaction
// in flight, and a watchdog that aborts a stalled R phase. TIMEOUT must be at least 2.
`ifndef AXI_POINTER_BITS
`define AXI_POINTER_BITS 1
`endif

module axi_rd_arbiter #(
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic                         m0_arvalid,
    input  logic                         m1_arvalid,
    input  logic                         s_arready,
    input  logic                         s_rvalid,
    input  logic                         s_rready,
    input  logic                         s_rlast,
    output logic [`AXI_POINTER_BITS-1:0] sel,
    output logic                         ar_en,
    output logic                         r_en,
    output logic                         busy,
    output logic                         timeout_err,
    output logic [7:0]                   beat_cnt
);

    localparam int unsigned PTR_W = `AXI_POINTER_BITS;
    localparam logic [PTR_W-1:0] SEL0 = PTR_W'(0);
    localparam logic [PTR_W-1:0] SEL1 = PTR_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StAddr,
        StData
    } state_e;

    state_e           state;
    logic [PTR_W-1:0] last_grant;
    logic [CNT_W-1:0] wdog;

    logic [PTR_W-1:0] winner;
    logic             gnt_arvalid;
    logic             r_hs;
    logic [CNT_W-1:0] wdog_inc;
    logic             wdog_expire;

    // On a tie the master that did not complete the previous AR wins.
    always_comb begin
        winner = SEL1;
        if (m0_arvalid && m1_arvalid) begin
            winner = (last_grant == SEL0) ? SEL1 : SEL0;
        end else if (m0_arvalid) begin
            winner = SEL0;
        end
    end

    assign gnt_arvalid = (sel == SEL0) ? m0_arvalid : m1_arvalid;
    assign r_hs        = s_rvalid & s_rready;
    assign wdog_inc    = wdog + CNT_W'(1);
    assign wdog_expire = (wdog_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state       <= StIdle;
            sel         <= SEL0;
            ar_en       <= 1'b0;
            r_en        <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            beat_cnt    <= 8'd0;
            wdog        <= '0;
            last_grant  <= SEL1;
        end else begin
            timeout_err <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (m0_arvalid || m1_arvalid) begin
                        state <= StAddr;
                        sel   <= winner;
                        ar_en <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                StAddr: begin
                    // Grant is held even if the granted master withdraws its request.
                    if (gnt_arvalid && s_arready) begin
                        state      <= StData;
                        last_grant <= sel;
                        ar_en      <= 1'b0;
                        r_en       <= 1'b1;
                        beat_cnt   <= 8'd0;
                        wdog       <= '0;
                    end
                end
                StData: begin
                    // A beat on the expiry cycle wins over the abort.
                    if (r_hs) begin
                        wdog <= '0;
                        if (beat_cnt != 8'hFF) begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                        if (s_rlast) begin
                            state <= StIdle;
                            r_en  <= 1'b0;
                            busy  <= 1'b0;
                        end
                    end else if (wdog_expire) begin
                        state       <= StIdle;
                        r_en        <= 1'b0;
                        busy        <= 1'b0;
                        wdog        <= '0;
                        timeout_err <= 1'b1;
                    end else begin
                        wdog <= wdog_inc;
                    end
                end
                default: begin
                    state <= StIdle;
                    ar_en <= 1'b0;
                    r_en  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    ar_r_exclusive: assert property (@(posedge ACLK) disable iff (!ARESETn) !(ar_en && r_en));
    busy_tracks_state: assert property (@(posedge ACLK) disable iff (!ARESETn)
        busy == (state != StIdle));
`endif

endmodule
